// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N_BITS-wide 8:1 mux between 8 requesters.
// A grant lasts up to MAX_HOLD accepted beats, or ends early when the granted
// requester drops its request. One IDLE cycle always separates two grants.
//
// Output handshake: Out_Valid/Out_Ready form a valid/ready pair; a beat moves
// on every cycle where both are high, and Ack strobes the granted requester in
// that same cycle. While Out_Valid is high and Out_Ready is low, all state is
// held and Out_Data stays stable.
module rr_mux_arbiter #(
   parameter int N_BITS   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        Request,
   input  logic [N_BITS-1:0] Data_0,
   input  logic [N_BITS-1:0] Data_1,
   input  logic [N_BITS-1:0] Data_2,
   input  logic [N_BITS-1:0] Data_3,
   input  logic [N_BITS-1:0] Data_4,
   input  logic [N_BITS-1:0] Data_5,
   input  logic [N_BITS-1:0] Data_6,
   input  logic [N_BITS-1:0] Data_7,
   input  logic              Out_Ready,
   output logic [7:0]        Grant,
   output logic [2:0]        Selector,
   output logic [N_BITS-1:0] Out_Data,
   output logic              Out_Valid,
   output logic [7:0]        Ack,
   output logic              Busy
);

   localparam int BW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  ptr_q, ptr_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [7:0]  grant_q, grant_d;
   logic [2:0]  sel_q, sel_d;

   logic        pick_found;
   logic [2:0]  pick_idx;
   logic [2:0]  scan_idx;
   logic [N_BITS-1:0] mux_data;
   logic        out_valid;
   logic        xfer;

   // Rotating priority scan: first requester at or after the pointer wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = 3'd0;
      scan_idx   = 3'd0;
      for (int i = 0; i < 8; i++) begin
         scan_idx = ptr_q + 3'(i);
         if (!pick_found && Request[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   // Shared 8:1 data mux steered by the registered selector.
   always_comb begin
      mux_data = '0;
      case (sel_q)
         3'd0: mux_data = Data_0;
         3'd1: mux_data = Data_1;
         3'd2: mux_data = Data_2;
         3'd3: mux_data = Data_3;
         3'd4: mux_data = Data_4;
         3'd5: mux_data = Data_5;
         3'd6: mux_data = Data_6;
         default: mux_data = Data_7;
      endcase
   end

   // Output port: valid only while the granted requester still requests.
   always_comb begin
      out_valid = (state_q == GRANT) && Request[sel_q];
      xfer      = out_valid && Out_Ready;
      Out_Valid = out_valid;
      Out_Data  = out_valid ? mux_data : '0;
      Ack       = xfer ? grant_q : 8'd0;
   end

   // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      beat_d  = beat_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = GRANT;
               grant_d = 8'd1 << pick_idx;
               sel_d   = pick_idx;
               beat_d  = '0;
            end
         end
         GRANT: begin
            if (!out_valid || (xfer && (beat_q == LAST_BEAT))) begin
               state_d = IDLE;
               ptr_d   = sel_q + 3'd1;
               grant_d = 8'd0;
               sel_d   = 3'd0;
               beat_d  = '0;
            end else if (xfer) begin
               beat_d = beat_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 8'd0;
            sel_d   = 3'd0;
            beat_d  = '0;
         end
      endcase
   end

   // State registers; reset dominates and aborts any grant in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         beat_q  <= '0;
         grant_q <= 8'd0;
         sel_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         beat_q  <= beat_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
      end
   end

   assign Grant    = grant_q;
   assign Selector = sel_q;
   assign Busy     = (state_q == GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter (N_BITS = 8, MAX_HOLD = 4): directed steps in one
// initial block; each expected output beat {index, data} is queued when the
// stimulus is set up and popped when the DUT transfers a beat.
module tb_rr_mux_arbiter;

   logic       clk;
   logic       reset;
   logic [7:0] req;
   logic [7:0] data_v [8];
   logic       out_ready;
   logic [7:0] grant;
   logic [2:0] selector;
   logic [7:0] out_data;
   logic       out_valid;
   logic [7:0] ack;
   logic       busy;

   logic [10:0] exp_q[$];
   int checks;
   int failures;

   rr_mux_arbiter #(.N_BITS(8), .MAX_HOLD(4)) dut (
      .clk(clk), .reset(reset), .Request(req),
      .Data_0(data_v[0]), .Data_1(data_v[1]), .Data_2(data_v[2]), .Data_3(data_v[3]),
      .Data_4(data_v[4]), .Data_5(data_v[5]), .Data_6(data_v[6]), .Data_7(data_v[7]),
      .Out_Ready(out_ready), .Grant(grant), .Selector(selector), .Out_Data(out_data),
      .Out_Valid(out_valid), .Ack(ack), .Busy(busy)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // global time limit
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_beats(input int idx, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back({3'(idx), data_v[idx]});
   endtask

   // One clock cycle: scoreboard any transfer, then step past the edge.
   task automatic cyc();
      logic [10:0] e;
      #2;
      if (!reset && out_valid && out_ready) begin
         chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat_sel", 32'(selector), 32'(e[10:8]));
            chk("beat_data", 32'(out_data), 32'(e[7:0]));
            chk("beat_ack", 32'(ack), 32'(8'd1 << e[10:8]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_grant"}, 32'(grant), 32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_ack"}, 32'(ack), 32'd0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      req = 8'hFF;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) data_v[i] = 8'h00;

      // reset with all requests high
      cyc();
      cyc();
      chk_idle("reset");
      chk("reset_sel", 32'(selector), 32'd0);
      chk("reset_data", 32'(out_data), 32'd0);

      // single requester 3
      reset = 1'b0;
      req = 8'h08;
      data_v[3] = 8'hA5;
      #1;
      chk_idle("single_pre");
      cyc();
      chk("single_grant", 32'(grant), 32'h08);
      chk("single_sel", 32'(selector), 32'd3);
      chk("single_busy", 32'(busy), 32'd1);
      push_beats(3, 4);
      for (int b = 0; b < 4; b++) cyc();
      chk_idle("single_gap");
      chk("single_q_empty", 32'(exp_q.size()), 32'd0);
      cyc();
      chk("single_regrant", 32'(grant), 32'h08);
      req = 8'h00;
      cyc();
      chk_idle("single_drop");

      // full contention from pointer 0
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) data_v[i] = 8'($urandom_range(0, 255));
      req = 8'hFF;
      cyc();
      for (int g = 0; g < 9; g++) begin
         chk("rr_grant", 32'(grant), 32'(8'd1 << (g % 8)));
         chk("rr_sel", 32'(selector), 32'(g % 8));
         push_beats(g % 8, 4);
         for (int b = 0; b < 4; b++) cyc();
         chk_idle("rr_gap");
         if (g < 8) cyc();
      end
      req = 8'h00;
      chk("rr_q_empty", 32'(exp_q.size()), 32'd0);

      // backpressure on requester 5 (pointer is 1 here)
      req = 8'h20;
      cyc();
      chk("bp_grant", 32'(grant), 32'h20);
      push_beats(5, 4);
      cyc();
      cyc();
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_data", 32'(out_data), 32'(data_v[5]));
         chk("bp_ack", 32'(ack), 32'd0);
         cyc();
         chk("bp_hold", 32'(grant), 32'h20);
      end
      out_ready = 1'b1;
      cyc();
      chk("bp_busy_3", 32'(busy), 32'd1);
      cyc();
      chk_idle("bp_done");
      chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

      // early release of requester 2 with 6 pending (pointer is 6 here)
      req = 8'h04;
      cyc();
      chk("er_grant2", 32'(grant), 32'h04);
      req = 8'h44;
      push_beats(2, 2);
      cyc();
      cyc();
      req = 8'h40;
      #1;
      chk("er_valid_low", 32'(out_valid), 32'd0);
      chk("er_data_zero", 32'(out_data), 32'd0);
      cyc();
      chk_idle("er_gap");
      cyc();
      chk("er_grant6", 32'(grant), 32'h40);
      chk("er_sel6", 32'(selector), 32'd6);
      req = 8'h00;
      cyc();
      chk_idle("er_drop");
      chk("er_q_empty", 32'(exp_q.size()), 32'd0);

      // wrap: pointer is 7, requesters 7 and 0
      req = 8'h81;
      cyc();
      chk("wrap_grant7", 32'(grant), 32'h80);
      push_beats(7, 4);
      for (int b = 0; b < 4; b++) cyc();
      chk_idle("wrap_gap");
      cyc();
      chk("wrap_grant0", 32'(grant), 32'h01);
      chk("wrap_sel0", 32'(selector), 32'd0);

      // reset on beat 2 of the grant to requester 0
      push_beats(0, 1);
      cyc();
      reset = 1'b1;
      cyc();
      chk_idle("midrst");
      chk("midrst_sel", 32'(selector), 32'd0);
      chk("midrst_data", 32'(out_data), 32'd0);
      reset = 1'b0;
      cyc();
      chk("midrst_regrant0", 32'(grant), 32'h01);
      push_beats(0, 4);
      for (int b = 0; b < 4; b++) cyc();
      chk_idle("midrst_done");
      req = 8'h00;
      cyc();
      chk("final_q_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one N_BITS-wide 8:1 multiplexer path between 8 requesters. It drives the mux Selector from its grant state machine and presents the selected data on a single valid/ready output port.
- Each grant allows up to MAX_HOLD beats before the next requester is arbitrated.
- Sits between the 8 producer blocks and a single shared consumer such as a register bank or output stage.

Parameters:
- N_BITS, 8, data width of each requester and of the output.
- MAX_HOLD, 4, maximum beats per grant; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Request  input  8  Request[i] high means requester i has data on Data_i.
- Data_0 .. Data_7  input  N_BITS each  requester data; held stable while Request[i] is high.
- Out_Ready  input  1  consumer accepts Out_Data this cycle.
- Grant  output  8  one-hot registered grant; all zeros when no grant is active.
- Selector  output  3  registered binary index of the granted requester; drives the shared 8:1 mux.
- Out_Data  output  N_BITS  selected data.
- Out_Valid  output  1  Out_Data is valid.
- Ack  output  8  one-hot beat-accepted strobe to requesters.
- Busy  output  1  high while in state GRANT.

Behaviour:
- Reset (synchronous, active-high; dominates all other events):
  - state returns to IDLE.
  - Pointer = 0, Beat_Count = 0.
  - Grant = 0, Selector = 0, Out_Valid = 0, Out_Data = 0, Ack = 0, Busy = 0.
- Reset asserted mid-grant aborts the grant; a beat in that cycle is not counted.
- Internal registers:
  - Pointer (3 bits): the highest-priority index.
  - Beat_Count: width clog2(MAX_HOLD), minimum 1 bit.
- State IDLE:
  - If Request is nonzero, select the first i with Request[i]=1, scanning Pointer, Pointer+1, ... up to 7 and wrapping to 0.
  - Next cycle: state GRANT, Grant = one-hot(i), Selector = i, Beat_Count = 0.
  - If Request is 0, stay in IDLE.
  - Latency: a request seen in IDLE at edge k is granted from cycle k+1.
- State GRANT:
  - Out_Valid = Request[Selector], combinational from the registered Selector.
  - Out_Data = mux(Data_x, Selector) when Out_Valid is high, otherwise 0.
  - Ack = Grant when (Out_Valid & Out_Ready), otherwise 0. This is combinational, same cycle as the transfer.
- Transfer = Out_Valid & Out_Ready; Beat_Count increments on each transfer.
- Transfer with Beat_Count == MAX_HOLD-1:
  - Next state IDLE, Pointer = Selector+1 (mod 8).
  - Grant and Selector clear to 0 at the same edge.
- Request[Selector] low while in GRANT: no transfer; next state IDLE, Pointer = Selector+1.
- Out_Ready low with Out_Valid high: hold all state; Out_Data stays stable; Ack = 0.
- One IDLE bubble cycle always separates consecutive grants, including a re-grant to the same requester.
- Request changes on non-granted lines have no effect during GRANT.
- MAX_HOLD = 1: every grant ends after a single beat.
- Pointer wraps from 7 to 0.
- Beat_Count never exceeds MAX_HOLD-1.

Test Plan:
- Reset: assert reset with Request = 8'hFF for 2 cycles -> Grant = 0, Selector = 0, Out_Valid = 0, Out_Data = 0, Ack = 0, Busy = 0.
- Single requester: Request = 8'h08, Data_3 = 8'hA5, Out_Ready = 1, MAX_HOLD = 4.
  - Grant = 8'h08 and Selector = 3 one cycle after the request.
  - Then 4 cycles of Out_Valid = 1, Out_Data = 8'hA5, Ack = 8'h08.
  - Then 1 IDLE cycle, then Grant = 8'h08 again.
- Full contention: Request = 8'hFF held, Out_Ready = 1 -> grant order 0,1,2,...,7,0, each with 4 Ack beats and a 1-cycle gap.
- Backpressure: during a grant to requester 5, Out_Ready = 0 for 3 cycles.
  - Out_Valid = 1, Out_Data = Data_5 stable, Ack = 0, Beat_Count unchanged.
  - Grant still completes exactly 4 beats.
- Early release: requester 2 is granted and drops Request after 2 beats, with Request[6] also pending -> one IDLE cycle, then Grant = 8'h40.
- Wrap and reset mid-grant:
  - Pointer = 7, Request = 8'h81 -> requester 7 is granted first, then requester 0.
  - Reset asserted on beat 2 of a grant -> next cycle all outputs 0; the following grant starts from requester 0.
